// File: rtl/alu_result_queue_pkg.sv
// ============================================================================
// Module      : alu_result_queue_pkg
// Description : Opcode constants, flag bit indices and opcode decode shared by
//               the ALU result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_result_queue_pkg;

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b1011;
  localparam logic [3:0] OP_SLL = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SRA = 4'b1110;
  localparam logic [3:0] OP_CPY = 4'b1111;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_W = 3;

  typedef enum logic [2:0] {
    SEL_ILLEGAL = 3'd0,
    SEL_ADD_SUB = 3'd1,
    SEL_NOT     = 3'd2,
    SEL_OR      = 3'd3,
    SEL_AND     = 3'd4,
    SEL_XOR     = 3'd5,
    SEL_SHIFT   = 3'd6,
    SEL_PASS    = 3'd7
  } sel_e;

  function automatic sel_e decode_op(input logic [3:0] op);
    sel_e sel;
    case (op)
      OP_ADD, OP_SUB:         sel = SEL_ADD_SUB;
      OP_NOT:                 sel = SEL_NOT;
      OP_OR:                  sel = SEL_OR;
      OP_AND:                 sel = SEL_AND;
      OP_XOR:                 sel = SEL_XOR;
      OP_SLL, OP_SRL, OP_SRA: sel = SEL_SHIFT;
      OP_CPY:                 sel = SEL_PASS;
      default:                sel = SEL_ILLEGAL;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_result_fifo.sv
// ============================================================================
// Module      : alu_result_fifo
// Description : Generic DEPTH-entry synchronous FIFO with occupancy count;
//               head data reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // Full blocks the push even when a pop frees a slot this same cycle.
  assign do_push = push_valid & ~full;
  assign do_pop  = pop_ready & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign push_ready = ~full;
  assign pop_valid  = ~empty;
  assign pop_data   = empty ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/alu_result_queue.sv
// ============================================================================
// Module      : alu_result_queue
// Description : Selects one ALU result by opcode and queues it with illegal
//               marker, optional flags (macro ALU_FLAGS_EN) and error count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_queue
  import alu_result_queue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] add_sub_res,
  input  logic             add_sub_cout,
  input  logic [WIDTH-1:0] not_res,
  input  logic [WIDTH-1:0] or_res,
  input  logic [WIDTH-1:0] and_res,
  input  logic [WIDTH-1:0] xor_res,
  input  logic [WIDTH-1:0] shift_res,
  input  logic [WIDTH-1:0] pass_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_illegal,
  output logic [2:0]       out_flags,
  output logic [ERR_W-1:0] err_count
);

`ifdef ALU_FLAGS_EN
  localparam int ENTRY_W = WIDTH + 1 + FLAG_W;
`else
  localparam int ENTRY_W = WIDTH + 1;
`endif

  sel_e               sel;
  logic [WIDTH-1:0]   sel_data;
  logic               illegal;
  logic               push;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  always_comb begin
    sel      = decode_op(opcode);
    sel_data = '0;
    case (sel)
      SEL_ADD_SUB: sel_data = add_sub_res;
      SEL_NOT:     sel_data = not_res;
      SEL_OR:      sel_data = or_res;
      SEL_AND:     sel_data = and_res;
      SEL_XOR:     sel_data = xor_res;
      SEL_SHIFT:   sel_data = shift_res;
      SEL_PASS:    sel_data = pass_res;
      default:     sel_data = '0;
    endcase
  end

  assign illegal = (sel == SEL_ILLEGAL);
  assign push    = in_valid & in_ready;

`ifdef ALU_FLAGS_EN
  logic [FLAG_W-1:0] in_flags;

  always_comb begin
    in_flags = '0;
    if (illegal) begin
      in_flags[FLAG_Z] = 1'b1;
    end else begin
      in_flags[FLAG_Z] = (sel_data == '0);
      in_flags[FLAG_N] = sel_data[WIDTH-1];
      in_flags[FLAG_C] = (sel == SEL_ADD_SUB) & add_sub_cout;
    end
  end

  assign wr_entry  = {in_flags, illegal, sel_data};
  assign out_flags = rd_entry[ENTRY_W-1 -: FLAG_W];
`else
  logic unused_cout;

  assign unused_cout = add_sub_cout;
  assign wr_entry    = {illegal, sel_data};
  assign out_flags   = '0;
`endif

  alu_result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (wr_entry),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (rd_entry)
  );

  assign out_data    = rd_entry[WIDTH-1:0];
  assign out_illegal = rd_entry[WIDTH];

  // Saturates at all-ones so a stuck illegal source cannot wrap the count.
  always_comb begin
    err_count_d = err_count_q;
    if (push && illegal && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;

endmodule

`default_nettype wire
